// File: rtl/pe_mac_seq.sv
// Sequencer for one MAC PE: loads a weight, clears the accumulator, streams
// cfg_len activations, then returns the accumulated dot product through a result handshake.
// Optional macro PE_MAC_SEQ_STALL_CNT_EN enables the input-starvation counter on stall_cnt.
module pe_mac_seq #(
  parameter int DATA_WIDTH   = 8,
  parameter int WEIGHT_WIDTH = 8,
  parameter int ACC_WIDTH    = 32,
  parameter int LEN_WIDTH    = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  output logic                    start_ready,
  input  logic [WEIGHT_WIDTH-1:0] cfg_weight,
  input  logic [LEN_WIDTH-1:0]    cfg_len,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   in_data,
  input  logic                    abort,
  output logic                    busy,
  output logic                    pe_enable,
  output logic                    pe_clear_acc,
  output logic                    pe_load_weight,
  output logic [DATA_WIDTH-1:0]   pe_data,
  output logic [WEIGHT_WIDTH-1:0] pe_weight,
  input  logic [ACC_WIDTH-1:0]    pe_acc_out,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [ACC_WIDTH-1:0]    res_data,
  output logic [31:0]             stall_cnt
);

  typedef enum logic [2:0] {IDLE, LOADW, CLEAR, MAC, DRAIN, DONE} state_t;

  state_t                  state, state_nxt;
  logic [WEIGHT_WIDTH-1:0] w_q;
  logic [LEN_WIDTH-1:0]    len_q, cnt_q;
  logic [ACC_WIDTH-1:0]    res_q;
  logic                    accept;

  assign accept    = start && start_ready;
  assign busy      = (state != IDLE);
  assign res_valid = (state == DONE);
  assign res_data  = res_q;
  assign pe_weight = w_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    start_ready    = 1'b0;
    in_ready       = 1'b0;
    pe_enable      = 1'b0;
    pe_clear_acc   = 1'b0;
    pe_load_weight = 1'b0;
    pe_data        = '0;
    case (state)
      IDLE: begin
        // gated by rst_n so start_ready stays low while reset is held
        start_ready = rst_n;
        if (start && rst_n) state_nxt = LOADW;
      end
      LOADW: begin
        pe_load_weight = 1'b1;
        state_nxt      = CLEAR;
      end
      CLEAR: begin
        pe_clear_acc = 1'b1;
        state_nxt    = (len_q != '0) ? MAC : DRAIN;
      end
      MAC: begin
        in_ready  = 1'b1;
        pe_data   = in_data;
        pe_enable = in_valid;
        if (in_valid && cnt_q == LEN_WIDTH'(1)) state_nxt = DRAIN;
      end
      DRAIN:   state_nxt = DONE;
      DONE:    if (res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort && state != IDLE) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_q   <= '0;
      len_q <= '0;
      cnt_q <= '0;
      res_q <= '0;
    end else begin
      if (accept) begin
        w_q   <= cfg_weight;
        len_q <= cfg_len;
      end
      if (state == CLEAR)              cnt_q <= len_q;
      else if (state == MAC && in_valid) cnt_q <= cnt_q - LEN_WIDTH'(1);
      // PE accumulator has absorbed the last beat by the DRAIN cycle
      if (state == DRAIN && !abort)    res_q <= pe_acc_out;
    end
  end

`ifdef PE_MAC_SEQ_STALL_CNT_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_q <= '0;
    else if (accept)
      stall_q <= '0;
    else if (state == MAC && !in_valid && stall_q != 32'hFFFF_FFFF)
      stall_q <= stall_q + 32'd1;
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

endmodule
